denise_palette_loader: RTL and testbench
========================================

// Module: denise_palette_loader
// PURPOSE
//  Initiator side of the Denise colour-register write path: accepts 24-bit RGB palette entries
//  (8-bit index + RGB888) from a streaming source (OSD/host palette DMA). Converts each entry into
//  colour-register write cycles (COLOR00-31 address, bank, LOCT, 12-bit data) on the 7MHz clock
//  enable, driving the same register bus the colour table decodes.
// PARAMETERS
//  DEPTH    4  input FIFO entries (power of two, >=2)
//  AGA      1  1: hi-nibble write (LOCT=0) then lo-nibble write (LOCT=1); 0: hi-nibble write only
// PORTS
//  clk              in   1   28MHz clock
//  reset            in   1   synchronous, active-high reset
//  clk7_en          in   1   7MHz clock enable; bus outputs advance only when high
//  in_valid         in   1   palette entry offered
//  in_ready         out  1   FIFO can accept (registered, = !full)
//  in_index         in   8   palette index 0..255
//  in_rgb           in   24  {R[7:0],G[7:0],B[7:0]}
//  reg_address_out  out  8   register address bits [8:1]
//  data_out         out  12  colour data {R4,G4,B4}
//  bank_out         out  3   colour bank select
//  loct_out         out  1   0: full 24-bit write (hi nibbles replicated), 1: low-nibble write
//  busy             out  1   FIFO non-empty or write sequence in progress
// BEHAVIOUR
//  - Reset: FIFO empty, state IDLE, reg_address_out=8'hFF (NOP reg 0x1FE), data_out=0, bank_out=0,
//    loct_out=0, busy=0, in_ready=1 on the cycle after reset deasserts.
//  - Push when in_valid && in_ready (any clk edge, independent of clk7_en). Pop only in IDLE on clk7_en.
//  - FSM (transitions only on clk7_en):
//    IDLE  -> WR_HI if FIFO non-empty (pop); else hold NOP outputs.
//    WR_HI: reg_address_out={3'b110,idx[4:0]}, bank_out=idx[7:5], loct_out=0,
//           data_out={R[7:4],G[7:4],B[7:4]}. Next: WR_LO if AGA else IDLE.
//    WR_LO: same address/bank, loct_out=1, data_out={R[3:0],G[3:0],B[3:0]}. Next: IDLE.
//  - Ordering fixed: hi before lo; a LOCT=0 write sets both halves, so reversal corrupts the lo half.
//  - Each write phase is asserted for exactly one clk7_en period; outputs registered, change only
//    on clk edges with clk7_en=1. IDLE drives NOP address between entries (one NOP period/entry).
//  - Throughput: AGA=1 one entry per 3 clk7_en periods; AGA=0 one per 2.
//  - Full: in_ready=0; in_valid ignored. Push and pop in same cycle: count unchanged, both happen.
//  - Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
//  - Reset mid-sequence: current write abandoned, FIFO flushed, NOP outputs next cycle.
//  - busy = (count!=0) || (state!=IDLE).
// STRUCTURE
//  - Shared package/include: COLORBASE (9'h180), NOP register address (9'h1FE), FSM state
//    encodings.
//  - One sub-module: palette_fifo (sync FIFO, DEPTH x 32: {index,rgb}, registered full/empty).
//  - Top: FSM, latched entry register, output registers.
// TESTING
//  1. Reset, then idx=8'h00 rgb=24'h123456 -> WR_HI addr 8'hC0 bank 0 loct 0 data 12'h135;
//     WR_LO loct 1 data 12'h246.
//  2. idx=8'hE5 rgb=24'hFFFFFF -> addr 8'hC5 bank 3'd7; data 12'hFFF both phases; then addr 8'hFF.
//  3. Push 6 entries back-to-back, DEPTH=4 -> in_ready low after 4th; all 6 emitted in order.
//     No loss or duplication; busy falls after last WR_LO.
//  4. clk7_en one-in-four -> each phase held exactly 4 clk cycles; no change on clk7_en=0.
//  5. Assert reset during WR_HI with 3 entries queued -> next cycle addr 8'hFF, busy=0;
//     no WR_LO issued.
//  6. AGA=0, idx=8'h1F rgb=24'hA0B0C0 -> single write addr 8'hDF data 12'hABC loct 0; no LOCT=1.
//  Scoreboard: model colortable write semantics, compare resulting 24-bit palette to pushed RGB.

Source files
------------

// File: rtl/denise_palette_loader_pkg.sv
// Shared constants and types for the Denise palette loader: colour register base,
// the NOP register used between writes, FSM states and the queued entry format.
package denise_palette_loader_pkg;

  localparam logic [8:0] COLORBASE = 9'h180;
  localparam logic [8:0] NOP_REG   = 9'h1FE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_HI = 2'd1,
    ST_WR_LO = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]  index;
    logic [23:0] rgb;
  } entry_t;

  // Register bus carries address bits [8:1]; COLORn sits at COLORBASE + 2n.
  function automatic logic [7:0] color_reg(input logic [4:0] n);
    color_reg = COLORBASE[8:1] + {3'b000, n};
  endfunction

endpackage

// File: rtl/denise_palette_loader_palette_fifo.sv
// Synchronous FIFO holding {index,rgb} palette entries with registered full/empty flags.
module palette_fifo
  import denise_palette_loader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  always_comb begin
    count_next = count_q;
    case ({do_push, do_pop})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_next;
      full    <= (count_next == CNT_W'(DEPTH));
      empty   <= (count_next == '0);
    end
  end

endmodule

// File: rtl/denise_palette_loader.sv
// Turns queued RGB888 palette entries into Denise colour-register write cycles,
// stepping once per 7MHz enable: NOP, hi-nibble write, then (AGA) lo-nibble write.
module denise_palette_loader
  import denise_palette_loader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AGA   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_index,
  input  logic [23:0] in_rgb,
  output logic [7:0]  reg_address_out,
  output logic [11:0] data_out,
  output logic [2:0]  bank_out,
  output logic        loct_out,
  output logic        busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t           state_q;
  state_t           state_d;
  entry_t           entry_q;
  entry_t           entry_d;
  entry_t           fifo_rd;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic [7:0]       addr_d;
  logic [11:0]      data_d;
  logic [2:0]       bank_d;
  logic             loct_d;

  palette_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid),
    .pop     (fifo_pop),
    .wr_data ({in_index, in_rgb}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign busy     = (fifo_count != '0) || (state_q != ST_IDLE);

  // Output values are derived from the next state so the bus and FSM stay aligned.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    fifo_pop = 1'b0;
    if (clk7_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            entry_d  = fifo_rd;
            state_d  = ST_WR_HI;
          end
        end
        ST_WR_HI: state_d = (AGA != 0) ? ST_WR_LO : ST_IDLE;
        ST_WR_LO: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    addr_d = NOP_REG[8:1];
    data_d = '0;
    bank_d = '0;
    loct_d = 1'b0;
    case (state_d)
      ST_WR_HI: begin
        addr_d = color_reg(entry_d.index[4:0]);
        bank_d = entry_d.index[7:5];
        data_d = {entry_d.rgb[23:20], entry_d.rgb[15:12], entry_d.rgb[7:4]};
      end
      ST_WR_LO: begin
        addr_d = color_reg(entry_d.index[4:0]);
        bank_d = entry_d.index[7:5];
        loct_d = 1'b1;
        data_d = {entry_d.rgb[19:16], entry_d.rgb[11:8], entry_d.rgb[3:0]};
      end
      default: begin
        addr_d = NOP_REG[8:1];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      entry_q         <= '0;
      reg_address_out <= NOP_REG[8:1];
      data_out        <= '0;
      bank_out        <= '0;
      loct_out        <= 1'b0;
    end else if (clk7_en) begin
      state_q         <= state_d;
      entry_q         <= entry_d;
      reg_address_out <= addr_d;
      data_out        <= data_d;
      bank_out        <= bank_d;
      loct_out        <= loct_d;
    end
  end

endmodule

// File: tb/tb_denise_palette_loader.sv
// Directed bench for denise_palette_loader: one AGA instance with a colour-table
// write model, plus an AGA=0 instance for the single-write case.
module tb_denise_palette_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        clk7_en = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_index = '0;
  logic [23:0] in_rgb = '0;
  logic [7:0]  reg_address_out;
  logic [11:0] data_out;
  logic [2:0]  bank_out;
  logic        loct_out;
  logic        busy;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_in_index = '0;
  logic [23:0] b_in_rgb = '0;
  logic [7:0]  b_addr;
  logic [11:0] b_data;
  logic [2:0]  b_bank;
  logic        b_loct;
  logic        b_busy;

  denise_palette_loader #(.DEPTH(4), .AGA(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .clk7_en         (clk7_en),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_index        (in_index),
    .in_rgb          (in_rgb),
    .reg_address_out (reg_address_out),
    .data_out        (data_out),
    .bank_out        (bank_out),
    .loct_out        (loct_out),
    .busy            (busy)
  );

  denise_palette_loader #(.DEPTH(4), .AGA(0)) dut_ecs (
    .clk             (clk),
    .reset           (reset),
    .clk7_en         (clk7_en),
    .in_valid        (b_in_valid),
    .in_ready        (b_in_ready),
    .in_index        (b_in_index),
    .in_rgb          (b_in_rgb),
    .reg_address_out (b_addr),
    .data_out        (b_data),
    .bank_out        (b_bank),
    .loct_out        (b_loct),
    .busy            (b_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int en_mode = 0;
  int en_phase = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [2:0]  bank;
    logic        loct;
    logic [11:0] data;
  } wr_t;

  wr_t         wlog[$];
  logic [23:0] pal [256];

  // Colour-table model: LOCT=0 replicates nibbles into both halves, LOCT=1 replaces low nibbles.
  always @(posedge clk) begin
    if (clk7_en && !reset) begin
      #1;
      if (reg_address_out != 8'hFF) begin
        logic [7:0]  pi;
        logic [23:0] old;
        wr_t         w;
        w.addr = reg_address_out;
        w.bank = bank_out;
        w.loct = loct_out;
        w.data = data_out;
        wlog.push_back(w);
        pi  = {bank_out, reg_address_out[4:0]};
        old = pal[pi];
        if (!loct_out)
          pal[pi] = {data_out[11:8], data_out[11:8], data_out[7:4], data_out[7:4],
                     data_out[3:0], data_out[3:0]};
        else
          pal[pi] = {old[23:20], data_out[11:8], old[15:12], data_out[7:4],
                     old[7:4], data_out[3:0]};
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    en_phase++;
    clk7_en = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? ((en_phase % 4) == 0) : 1'b0;
  endtask

  task automatic setEn(input int mode);
    en_mode  = mode;
    en_phase = 0;
    clk7_en  = (mode != 2);
  endtask

  task automatic applyStimulus(input logic [7:0] idx, input logic [23:0] rgb);
    logic accepted;
    accepted = 1'b0;
    in_index = idx;
    in_rgb   = rgb;
    in_valid = 1'b1;
    for (int k = 0; k < 60 && !accepted; k++) begin
      if (in_ready) accepted = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    checkOutput("push_accept", {31'd0, accepted}, 32'd1);
  endtask

  task automatic waitWrite(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      cycle();
      if (reg_address_out != 8'hFF) seen = 1'b1;
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 200 && !idle; k++) begin
      cycle();
      if (!busy) idle = 1'b1;
    end
    checkOutput(tag, {31'd0, idle}, 32'd1);
  endtask

  logic [7:0]  t3_idx [6];
  logic [23:0] t3_rgb [6];

  initial begin
    int hold;
    logic [7:0]  snap_addr;
    logic [11:0] snap_data;
    logic        snap_loct;
    logic [23:0] r;

    t3_idx[0] = 8'h03; t3_rgb[0] = 24'h0F1E2D;
    t3_idx[1] = 8'h24; t3_rgb[1] = 24'h3C4B5A;
    t3_idx[2] = 8'h4F; t3_rgb[2] = 24'h697887;
    t3_idx[3] = 8'h91; t3_rgb[3] = 24'h96A5B4;
    t3_idx[4] = 8'hB8; t3_rgb[4] = 24'hC3D2E1;
    t3_idx[5] = 8'hFE; t3_rgb[5] = 24'hF00FAA;
    for (int i = 0; i < 256; i++) pal[i] = '0;

    // Reset state
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    checkOutput("rst_addr", {24'd0, reg_address_out}, 32'hFF);
    checkOutput("rst_data", {20'd0, data_out}, 32'h0);
    checkOutput("rst_bank", {29'd0, bank_out}, 32'h0);
    checkOutput("rst_loct", {31'd0, loct_out}, 32'h0);
    checkOutput("rst_busy", {31'd0, busy}, 32'h0);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'h1);

    // Test 1: basic hi/lo sequence
    applyStimulus(8'h00, 24'h123456);
    waitWrite("t1_wait");
    checkOutput("t1_hi_addr", {24'd0, reg_address_out}, 32'hC0);
    checkOutput("t1_hi_bank", {29'd0, bank_out}, 32'h0);
    checkOutput("t1_hi_loct", {31'd0, loct_out}, 32'h0);
    checkOutput("t1_hi_data", {20'd0, data_out}, 32'h135);
    checkOutput("t1_busy", {31'd0, busy}, 32'h1);
    cycle();
    checkOutput("t1_lo_addr", {24'd0, reg_address_out}, 32'hC0);
    checkOutput("t1_lo_loct", {31'd0, loct_out}, 32'h1);
    checkOutput("t1_lo_data", {20'd0, data_out}, 32'h246);
    cycle();
    checkOutput("t1_nop_addr", {24'd0, reg_address_out}, 32'hFF);
    checkOutput("t1_idle_busy", {31'd0, busy}, 32'h0);
    checkOutput("t1_palette", {8'd0, pal[0]}, 32'h123456);

    // Test 2: top bank, all-ones colour
    applyStimulus(8'hE5, 24'hFFFFFF);
    waitWrite("t2_wait");
    checkOutput("t2_hi_addr", {24'd0, reg_address_out}, 32'hC5);
    checkOutput("t2_hi_bank", {29'd0, bank_out}, 32'h7);
    checkOutput("t2_hi_data", {20'd0, data_out}, 32'hFFF);
    cycle();
    checkOutput("t2_lo_loct", {31'd0, loct_out}, 32'h1);
    checkOutput("t2_lo_data", {20'd0, data_out}, 32'hFFF);
    checkOutput("t2_lo_bank", {29'd0, bank_out}, 32'h7);
    cycle();
    checkOutput("t2_nop_addr", {24'd0, reg_address_out}, 32'hFF);
    checkOutput("t2_palette", {8'd0, pal[8'hE5]}, 32'hFFFFFF);

    // Test 3: six entries into a 4-deep FIFO, enable held off until it fills
    wlog.delete();
    setEn(2);
    for (int i = 0; i < 4; i++) applyStimulus(t3_idx[i], t3_rgb[i]);
    checkOutput("t3_full_ready", {31'd0, in_ready}, 32'h0);
    checkOutput("t3_full_busy", {31'd0, busy}, 32'h1);
    in_index = t3_idx[4];
    in_rgb   = t3_rgb[4];
    in_valid = 1'b1;
    cycle();
    cycle();
    checkOutput("t3_still_full", {31'd0, in_ready}, 32'h0);
    checkOutput("t3_no_write", wlog.size(), 32'd0);
    setEn(0);
    applyStimulus(t3_idx[4], t3_rgb[4]);
    applyStimulus(t3_idx[5], t3_rgb[5]);
    waitIdle("t3_drain");
    checkOutput("t3_wr_count", wlog.size(), 32'd12);
    if (wlog.size() == 12) begin
      for (int i = 0; i < 6; i++) begin
        r = t3_rgb[i];
        checkOutput($sformatf("t3_hi_addr%0d", i), {24'd0, wlog[2*i].addr},
                    {24'd0, 8'hC0 | {3'b000, t3_idx[i][4:0]}});
        checkOutput($sformatf("t3_hi_bank%0d", i), {29'd0, wlog[2*i].bank}, {29'd0, t3_idx[i][7:5]});
        checkOutput($sformatf("t3_hi_loct%0d", i), {31'd0, wlog[2*i].loct}, 32'h0);
        checkOutput($sformatf("t3_hi_data%0d", i), {20'd0, wlog[2*i].data},
                    {20'd0, r[23:20], r[15:12], r[7:4]});
        checkOutput($sformatf("t3_lo_loct%0d", i), {31'd0, wlog[2*i+1].loct}, 32'h1);
        checkOutput($sformatf("t3_lo_data%0d", i), {20'd0, wlog[2*i+1].data},
                    {20'd0, r[19:16], r[11:8], r[3:0]});
      end
    end
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t3_palette%0d", i), {8'd0, pal[t3_idx[i]]}, {8'd0, t3_rgb[i]});
    checkOutput("t3_last_loct", {31'd0, wlog[$].loct}, 32'h1);

    // Test 4: one-in-four clock enable, each phase held four clocks
    setEn(1);
    applyStimulus(8'h0A, 24'h89ABCD);
    waitWrite("t4_wait");
    checkOutput("t4_hi_data", {20'd0, data_out}, 32'h8AC);
    snap_addr = reg_address_out; snap_data = data_out; snap_loct = loct_out;
    hold = 1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (reg_address_out != snap_addr || data_out != snap_data || loct_out != snap_loct) break;
      hold++;
    end
    checkOutput("t4_hi_hold", hold, 32'd4);
    checkOutput("t4_lo_data", {20'd0, data_out}, 32'h9BD);
    checkOutput("t4_lo_loct", {31'd0, loct_out}, 32'h1);
    snap_addr = reg_address_out; snap_data = data_out; snap_loct = loct_out;
    hold = 1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (reg_address_out != snap_addr || data_out != snap_data || loct_out != snap_loct) break;
      hold++;
    end
    checkOutput("t4_lo_hold", hold, 32'd4);
    checkOutput("t4_nop_addr", {24'd0, reg_address_out}, 32'hFF);
    checkOutput("t4_palette", {8'd0, pal[8'h0A]}, 32'h89ABCD);
    setEn(0);
    waitIdle("t4_drain");

    // Test 5: reset during WR_HI with three entries still queued
    setEn(2);
    for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i), 24'h555555 + 24'(i));
    setEn(0);
    waitWrite("t5_wait");
    checkOutput("t5_in_hi", {31'd0, loct_out}, 32'h0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    wlog.delete();
    checkOutput("t5_rst_addr", {24'd0, reg_address_out}, 32'hFF);
    checkOutput("t5_rst_busy", {31'd0, busy}, 32'h0);
    checkOutput("t5_rst_ready", {31'd0, in_ready}, 32'h1);
    checkOutput("t5_rst_loct", {31'd0, loct_out}, 32'h0);
    repeat (12) cycle();
    checkOutput("t5_no_writes", wlog.size(), 32'd0);
    checkOutput("t5_idle_addr", {24'd0, reg_address_out}, 32'hFF);

    // Test 6: AGA=0 instance issues a single hi-nibble write
    checkOutput("t6_ready", {31'd0, b_in_ready}, 32'h1);
    b_in_index = 8'h1F;
    b_in_rgb   = 24'hA0B0C0;
    b_in_valid = 1'b1;
    cycle();
    b_in_valid = 1'b0;
    hold = 0;
    for (int k = 0; k < 40 && b_addr == 8'hFF; k++) begin
      cycle();
      hold++;
    end
    checkOutput("t6_addr", {24'd0, b_addr}, 32'hDF);
    checkOutput("t6_data", {20'd0, b_data}, 32'hABC);
    checkOutput("t6_loct", {31'd0, b_loct}, 32'h0);
    checkOutput("t6_bank", {29'd0, b_bank}, 32'h0);
    cycle();
    checkOutput("t6_nop_addr", {24'd0, b_addr}, 32'hFF);
    checkOutput("t6_no_lo", {31'd0, b_loct}, 32'h0);
    checkOutput("t6_busy", {31'd0, b_busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
